// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard and pipeline-control unit for the 5-stage core. Produces
//            the stall (en) and flush (clr) controls for the IF/ID, ID/EX,
//            EX/MEM and MEM/WB pipe registers and the EX-stage forwarding
//            selects. Resolves load-use hazards, taken-branch flushes and
//            variable-latency data-memory waits, abandoning an access that
//            has been waited on for TIMEOUT cycles. Keeps saturating stall
//            and flush statistics counters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT        : stalled cycles allowed per data-memory access (>= 2)
//   CNT_W          : width of the statistics counters
// Ports
//   clk            : clock, rising edge
//   reset_i        : asynchronous active-high reset
//   rs1_d, rs2_d   : source registers of the ID instruction
//   rs1_e, rs2_e   : source registers of the EX instruction
//   rd_e           : destination register of the EX instruction
//   rd_m, rd_w     : destination registers of the MEM / WB instructions
//   reg_write_m/_w : MEM / WB instruction writes the register file
//   load_e         : EX instruction is a load
//   pc_src_e       : EX branch or jump is taken
//   mem_req_m      : MEM instruction accesses data memory (held until done)
//   mem_ready_i    : data memory completes the access this cycle
//   forward_a_e/_b_e : 00 register file, 10 MEM ALU result, 01 WB result
//   stall_f        : hold the PC
//   stall_d        : IF/ID enable (high holds)
//   flush_d        : IF/ID clear (loads a NOP)
//   flush_e        : ID/EX clear (loads a bubble)
//   stall_e/_m/_w  : hold the ID/EX, EX/MEM and MEM/WB registers
//   mem_timeout_o  : one-cycle pulse when an access is abandoned
//   stall_cnt_o    : saturating count of cycles with stall_f high
//   flush_cnt_o    : saturating count of cycles with flush_d high
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_i,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Wait counter must hold TIMEOUT-1; never narrower than 5 bits.
    localparam int c_WCNT_W = (($clog2(TIMEOUT) + 1) > 5) ? ($clog2(TIMEOUT) + 1) : 5;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_FWD_WB  = 2'b01;

    logic [1:0]          r_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic       w_mw;
    logic       w_lu;
    logic       w_br;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_stall_w;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = c_FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = c_FWD_WB;
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_sel(rs1_e);
    assign w_fwd_b = fwd_sel(rs2_e);

    assign w_lu = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign w_br = pc_src_e;

    // Memory wait: in RUN a fresh request without ready starts the wait;
    // in WAIT the request is known to be held, so only ready matters;
    // ERR releases the pipeline so it steps past the failed access.
    always_comb begin
        w_mw = 1'b0;
        case (r_state)
            c_ST_RUN:  w_mw = mem_req_m && !mem_ready_i;
            c_ST_WAIT: w_mw = !mem_ready_i;
            default:   w_mw = 1'b0;
        endcase
    end

    // Priority: memory wait > branch > load-use. During a memory wait EX is
    // held, so a pending branch or load-use is simply re-evaluated afterwards.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        if (reset_i) begin
            w_stall_f = 1'b0;
        end else if (w_mw) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else if (w_br) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lu) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    assign forward_a_e   = reset_i ? c_FWD_RF : w_fwd_a;
    assign forward_b_e   = reset_i ? c_FWD_RF : w_fwd_b;
    assign stall_f       = w_stall_f;
    assign stall_d       = w_stall_d;
    assign flush_d       = w_flush_d;
    assign flush_e       = w_flush_e;
    assign stall_e       = w_stall_e;
    assign stall_m       = w_stall_m;
    assign stall_w       = w_stall_w;
    assign mem_timeout_o = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

    // Memory-wait FSM. The timeout pulse is registered on the transition
    // into ERR, so it is high exactly for the single ERR cycle. Reset while
    // waiting drops the access without a pulse.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= c_ST_RUN;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (w_mw) begin
                        r_state <= c_ST_WAIT;
                        r_wcnt  <= c_WCNT_ONE;
                    end
                end
                c_ST_WAIT: begin
                    // Ready on the last allowed cycle still completes normally.
                    if (mem_ready_i) begin
                        r_state <= c_ST_RUN;
                        r_wcnt  <= '0;
                    end else if (r_wcnt == c_WCNT_LAST) begin
                        r_state   <= c_ST_ERR;
                        r_wcnt    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + c_WCNT_ONE;
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_RUN;
                    r_wcnt  <= '0;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_flush_d && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Two instances share
//            the stimulus: one with default parameters and one with 4-bit
//            counters to observe saturation. Each cycle's expected controls
//            and counter values are pushed to a scoreboard queue when the
//            stimulus is applied and popped when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Control vector order:
    // {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, flush_d, flush_e,
    //  stall_e, stall_m, stall_w, mem_timeout}
    localparam logic [11:0] c_IDLE = 12'h000;
    localparam logic [11:0] c_LU   = 12'h0D0;
    localparam logic [11:0] c_BR   = 12'h030;
    localparam logic [11:0] c_MW   = 12'h0CE;
    localparam logic [11:0] c_TO   = 12'h001;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m, mem_ready_i;

    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, stall_w, mem_timeout_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [1:0]  fa4, fb4;
    logic        sf4, sd4, fd4, fe4, se4, sm4, sw4, to4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    typedef struct {
        logic [11:0] ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_sc, m_fc;
    logic [3:0]  m_sc4, m_fc4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset_i(reset_i),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e),
        .mem_req_m(mem_req_m), .mem_ready_i(mem_ready_i),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .mem_timeout_o(mem_timeout_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk(clk), .reset_i(reset_i),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e),
        .mem_req_m(mem_req_m), .mem_ready_i(mem_ready_i),
        .forward_a_e(fa4), .forward_b_e(fb4),
        .stall_f(sf4), .stall_d(sd4), .flush_d(fd4), .flush_e(fe4),
        .stall_e(se4), .stall_m(sm4), .stall_w(sw4),
        .mem_timeout_o(to4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    function automatic logic [11:0] obs_ctl();
        return {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
                stall_e, stall_m, stall_w, mem_timeout_o};
    endfunction

    function automatic logic [11:0] obs_ctl4();
        return {fa4, fb4, sf4, sd4, fd4, fe4, se4, sm4, sw4, to4};
    endfunction

    task automatic clr_in();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; load_e = 0; pc_src_e = 0;
        mem_req_m = 0; mem_ready_i = 0;
    endtask

    task automatic clr_model();
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    endtask

    // Record the expected outputs of the cycle just driven, then advance the
    // counter model by what that cycle should contribute.
    task automatic push_exp(input logic [11:0] ctl);
        exp_t e;
        e.ctl = ctl; e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
        sb.push_back(e);
        if (ctl[7]) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc4 != 4'hF)    m_sc4 = m_sc4 + 4'd1;
        end
        if (ctl[5]) begin
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (m_fc4 != 4'hF)    m_fc4 = m_fc4 + 4'd1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            clr_in();
            if (i < 2) begin
                reset_i = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1; pc_src_e = 1;
                mem_req_m = 1; load_e = 1; rd_e = 3; rs1_d = 3;
                clr_model();
            end else begin
                reset_i = 0;
            end
            push_exp(c_IDLE);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL reset[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL reset[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 5; i++) begin
            clr_in();
            case (i)
                0: begin rs1_e = 5; rs2_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; x = 12'hA00; end
                1: begin rs1_e = 5; rs2_e = 5; rd_m = 5; rd_w = 5; reg_write_w = 1; x = 12'h500; end
                2: begin reg_write_m = 1; reg_write_w = 1; x = 12'h000; end
                3: begin rs1_e = 3; rs2_e = 4; rd_m = 4; rd_w = 3; reg_write_m = 1; reg_write_w = 1; x = 12'h600; end
                default: begin rs1_e = 6; rs2_e = 2; rd_m = 6; rd_w = 2; reg_write_w = 1; x = 12'h100; end
            endcase
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL forward[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL forward[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 7; i++) begin
            clr_in();
            case (i)
                0: begin load_e = 1; rd_e = 7; rs2_d = 7; x = c_LU; end
                1: x = c_IDLE;
                2: x = c_IDLE;  // rd_e = x0 never creates a hazard
                3: begin load_e = 1; rd_e = 9; rs1_d = 9; x = c_LU; end
                4: begin rd_e = 9; rs1_d = 9; x = c_IDLE; end
                5: begin load_e = 1; rd_e = 7; rs1_d = 7; pc_src_e = 1; x = c_BR; end
                default: x = c_IDLE;
            endcase
            if (i == 2) load_e = 1;
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL load_use[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL load_use[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 7; i++) begin
            clr_in();
            case (i)
                0: begin pc_src_e = 1; x = c_BR; end
                1: x = c_IDLE;
                2, 3, 4: begin pc_src_e = 1; mem_req_m = 1; x = c_MW; end
                5: begin pc_src_e = 1; mem_req_m = 1; mem_ready_i = 1; x = c_BR; end
                default: x = c_IDLE;
            endcase
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL branch[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL branch[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    // Ready on the 4th cycle, ready in the first cycle, then a back-to-back
    // access right after a completion.
    task automatic test_back_to_back();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 8; i++) begin
            clr_in();
            case (i)
                0, 1, 2: begin mem_req_m = 1; x = c_MW; end
                3: begin mem_req_m = 1; mem_ready_i = 1; x = c_IDLE; end
                4: begin mem_req_m = 1; mem_ready_i = 1; x = c_IDLE; end
                5: begin mem_req_m = 1; x = c_MW; end
                6: begin mem_req_m = 1; mem_ready_i = 1; x = c_IDLE; end
                default: x = c_IDLE;
            endcase
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL mem_wait[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL mem_wait[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    // Ready arrives on the very cycle the wait count reaches TIMEOUT-1.
    task automatic test_ready_at_limit();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 18; i++) begin
            clr_in();
            if (i < 15) begin
                mem_req_m = 1; x = c_MW;
            end else if (i == 15) begin
                mem_req_m = 1; mem_ready_i = 1; x = c_IDLE;
            end else begin
                x = c_IDLE;
            end
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL ready_limit[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL ready_limit[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 20; i++) begin
            clr_in();
            if (i < 16) begin
                mem_req_m = 1; x = c_MW;
            end else if (i == 16) begin
                mem_req_m = 1; x = c_TO;
            end else if (i == 17) begin
                mem_req_m = 1; x = c_MW;
            end else if (i == 18) begin
                mem_req_m = 1; mem_ready_i = 1; x = c_IDLE;
            end else begin
                x = c_IDLE;
            end
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL timeout[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL timeout[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset lands on the 3rd WAIT cycle; no timeout pulse may follow.
    task automatic test_reset_midwait();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 25; i++) begin
            clr_in();
            if (i < 3) begin
                mem_req_m = 1; x = c_MW;
            end else if (i < 5) begin
                mem_req_m = 1; reset_i = 1; clr_model(); x = c_IDLE;
            end else begin
                reset_i = 0; x = c_IDLE;
            end
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL reset_wait[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL reset_wait[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    // 20 load-use cycles: the 4-bit counter must stop at 15.
    task automatic test_saturation();
        exp_t e;
        logic [11:0] x;
        for (int i = 0; i < 22; i++) begin
            clr_in();
            if (i < 20) begin
                load_e = 1; rd_e = 12; rs2_d = 12; x = c_LU;
            end else begin
                x = c_IDLE;
            end
            push_exp(x);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({obs_ctl(), obs_ctl4()} !== {e.ctl, e.ctl}) begin
                failures++;
                $display("FAIL saturate[%0d] ctl actual=%h/%h required=%h", i, obs_ctl(), obs_ctl4(), e.ctl);
            end
            checks++;
            if ({stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4} !== {e.sc, e.fc, e.sc4, e.fc4}) begin
                failures++;
                $display("FAIL saturate[%0d] cnt actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, stall_cnt4, flush_cnt4, e.sc, e.fc, e.sc4, e.fc4);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clr_in();
        clr_model();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_ready_at_limit();
        test_timeout();
        test_reset_midwait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
